// File: rtl/noc_pkg.sv
// Shared NoC constants: VC numbering, flit class encodings and arbiter state type.
package noc_pkg;

  localparam int         NUM_VC    = 3;
  localparam logic [1:0] VC_EJECT  = 2'd0;
  localparam logic [1:0] VC_FWD    = 2'd1;
  localparam logic [1:0] VC_INJ    = 2'd2;
  localparam logic [1:0] VC_NONE   = 2'd3;
  localparam logic [5:0] HEAD_PAT  = 6'b101111;
  localparam logic [7:0] TRAILER   = 8'hFF;
  localparam logic [7:0] IDLE_FLIT = 8'h00;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  function automatic logic is_head(input logic [7:0] f);
    return f[7:2] == HEAD_PAT;
  endfunction

  function automatic logic is_trailer(input logic [7:0] f);
    return f == TRAILER;
  endfunction

  // Round-robin successor over the three VCs
  function automatic logic [1:0] vc_inc(input logic [1:0] v);
    return (v == VC_INJ) ? VC_EJECT : v + 2'd1;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO with show-ahead read data and occupancy count.
module vc_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_wr, w_rd;

  assign w_wr = wr_en & ~full;
  assign w_rd = rd_en & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule

// File: rtl/vc_buffer.sv
// Three-VC input buffer with round-robin output arbitration and packet locking
// from HEAD to TRAILER on the granted VC.
module vc_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        flit_in,
  input  logic [1:0]        vc_sel,
  output logic [7:0]        flit_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_vc,
  output logic [NUM_VC-1:0] vc_full,
  output logic [NUM_VC-1:0] vc_empty,
  output logic              drop_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_VC-1:0] w_wr_en, w_rd_en, w_full, w_empty;
  logic [7:0]        w_rd_data [NUM_VC];
  logic [CW-1:0]     w_count   [NUM_VC];
  logic              w_flit_nz, w_sel_full, w_drop, w_xfer;
  arb_state_t        r_state, w_state_nxt;
  logic [1:0]        r_lock_vc, w_lock_nxt, r_last, r_hold_vc, w_gnt_vc, w_cand;
  logic              r_hold, r_drop_err, w_gnt_valid;

  assign w_flit_nz = (flit_in != IDLE_FLIT);

  always_comb begin
    w_sel_full = 1'b1;
    case (vc_sel)
      VC_EJECT: w_sel_full = w_full[0];
      VC_FWD:   w_sel_full = w_full[1];
      VC_INJ:   w_sel_full = w_full[2];
      default:  w_sel_full = 1'b1;
    endcase
  end

  assign w_drop = w_flit_nz & w_sel_full;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign w_wr_en[i]  = w_flit_nz & (vc_sel == 2'(i)) & ~w_full[i];
    assign w_rd_en[i]  = w_xfer & (w_gnt_vc == 2'(i));
    assign vc_empty[i] = (w_count[i] == '0);

    vc_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wr_en[i]),
      .wr_data (flit_in),
      .rd_en   (w_rd_en[i]),
      .rd_data (w_rd_data[i]),
      .full    (w_full[i]),
      .empty   (w_empty[i]),
      .count   (w_count[i])
    );
  end

  assign vc_full = w_full;

  // A presented-but-unaccepted flit pins the grant so the output stays stable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_lock_vc  <= VC_EJECT;
      r_last     <= VC_INJ;
      r_hold     <= 1'b0;
      r_hold_vc  <= VC_EJECT;
      r_drop_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_vc  <= w_lock_nxt;
      r_hold     <= out_valid & ~out_ready;
      r_hold_vc  <= w_gnt_vc;
      r_drop_err <= w_drop;
      if (w_xfer) r_last <= w_gnt_vc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_vc;
    if (w_xfer) begin
      case (r_state)
        ARB_IDLE: begin
          if (is_head(flit_out)) begin
            w_state_nxt = ARB_LOCKED;
            w_lock_nxt  = w_gnt_vc;
          end
        end
        ARB_LOCKED: begin
          if (is_trailer(flit_out)) w_state_nxt = ARB_IDLE;
        end
        default: w_state_nxt = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_vc    = VC_EJECT;
    w_cand      = vc_inc(r_last);
    if (r_hold) begin
      w_gnt_valid = 1'b1;
      w_gnt_vc    = r_hold_vc;
    end else if (r_state == ARB_LOCKED) begin
      w_gnt_valid = ~w_empty[r_lock_vc];
      w_gnt_vc    = r_lock_vc;
    end else begin
      for (int k = 0; k < NUM_VC; k++) begin
        if (!w_gnt_valid && !w_empty[w_cand]) begin
          w_gnt_valid = 1'b1;
          w_gnt_vc    = w_cand;
        end
        w_cand = vc_inc(w_cand);
      end
    end
  end

  assign out_valid = w_gnt_valid;
  assign flit_out  = w_gnt_valid ? w_rd_data[w_gnt_vc] : IDLE_FLIT;
  assign out_vc    = w_gnt_valid ? w_gnt_vc : VC_EJECT;
  assign w_xfer    = out_valid & out_ready;
  assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_vc_buffer.sv
// Self-checking bench for vc_buffer: per-VC expected queues scored against observed transfers.
`timescale 1ns/1ps
module tb_vc_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] flit_in;
  logic [1:0] vc_sel;
  logic [7:0] flit_out;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_vc;
  logic [2:0] vc_full;
  logic [2:0] vc_empty;
  logic       drop_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] vc;
    logic [7:0] flit;
  } xfer_t;

  xfer_t      obs_q [$];
  logic [7:0] exp_q [3][$];

  always #5 clk = ~clk;

  vc_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flit_in   (flit_in),
    .vc_sel    (vc_sel),
    .flit_out  (flit_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vc    (out_vc),
    .vc_full   (vc_full),
    .vc_empty  (vc_empty),
    .drop_err  (drop_err)
  );

  // Record every transfer just before the rising edge that completes it
  always @(negedge clk) begin
    #3;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      obs_q.push_back({out_vc, flit_out});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic step(input logic [7:0] f, input logic [1:0] v, input logic r, input logic acc);
    @(negedge clk);
    #1;
    flit_in   = f;
    vc_sel    = v;
    out_ready = r;
    if (acc) exp_q[v].push_back(f);
  endtask

  task automatic flush_q();
    obs_q.delete();
    for (int k = 0; k < 3; k++) exp_q[k].delete();
  endtask

  task automatic reset_dut();
    rst = 1'b0; flit_in = 8'h00; vc_sel = 2'b00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    flush_q();
  endtask

  task automatic test_reset();
    rst = 1'b1; flit_in = 8'h00; vc_sel = 2'b00; out_ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    n_tests++; if (flit_out !== 8'h00) begin n_fail++; $display("FAIL rst_flit_out: got %h, required 00", flit_out); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    n_tests++; if (out_vc !== 2'b00) begin n_fail++; $display("FAIL rst_out_vc: got %b, required 00", out_vc); end
    n_tests++; if (vc_full !== 3'b000) begin n_fail++; $display("FAIL rst_vc_full: got %b, required 000", vc_full); end
    n_tests++; if (vc_empty !== 3'b111) begin n_fail++; $display("FAIL rst_vc_empty: got %b, required 111", vc_empty); end
    n_tests++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL rst_drop_err: got %b, required 0", drop_err); end
    @(negedge clk);
    rst = 1'b1;
    flush_q();
  endtask

  task automatic test_packet_latency();
    logic [1:0] ord [3] = '{2'd1, 2'd1, 2'd1};
    xfer_t x; logic [7:0] e;
    reset_dut();
    step(8'hBD, 2'd1, 1'b1, 1'b1);
    step(8'h11, 2'd1, 1'b1, 1'b1);
    n_tests++; if ({out_valid, out_vc, flit_out} !== {1'b1, 2'd1, 8'hBD}) begin n_fail++; $display("FAIL pkt_c1: got v=%b vc=%0d %h, required v=1 vc=1 bd", out_valid, out_vc, flit_out); end
    step(8'hFF, 2'd1, 1'b1, 1'b1);
    n_tests++; if ({out_valid, out_vc, flit_out} !== {1'b1, 2'd1, 8'h11}) begin n_fail++; $display("FAIL pkt_c2: got v=%b vc=%0d %h, required v=1 vc=1 11", out_valid, out_vc, flit_out); end
    step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if ({out_valid, out_vc, flit_out} !== {1'b1, 2'd1, 8'hFF}) begin n_fail++; $display("FAIL pkt_c3: got v=%b vc=%0d %h, required v=1 vc=1 ff", out_valid, out_vc, flit_out); end
    step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if ({out_valid, out_vc, flit_out} !== {1'b0, 2'd0, 8'h00}) begin n_fail++; $display("FAIL pkt_idle: got v=%b vc=%0d %h, required v=0 vc=0 00", out_valid, out_vc, flit_out); end
    n_tests++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL pkt_count: got %0d transfers, required 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      x = obs_q[i]; n_tests++;
      if (x.vc !== ord[i]) begin n_fail++; $display("FAIL pkt_order[%0d]: got vc%0d, required vc%0d", i, x.vc, ord[i]); end
      else if (exp_q[x.vc].size() == 0) begin n_fail++; $display("FAIL pkt_extra[%0d]: got %h, required nothing", i, x.flit); end
      else begin e = exp_q[x.vc].pop_front(); if (x.flit !== e) begin n_fail++; $display("FAIL pkt_data[%0d]: got %h, required %h", i, x.flit, e); end end
    end
  endtask

  task automatic test_full_drop();
    xfer_t x; logic [7:0] e;
    reset_dut();
    for (int i = 1; i <= 4; i++) step(8'(i), 2'd0, 1'b0, 1'b1);
    step(8'h05, 2'd0, 1'b0, 1'b0);
    n_tests++; if (vc_full !== 3'b001) begin n_fail++; $display("FAIL full_flag: got %b, required 001", vc_full); end
    n_tests++; if (vc_empty !== 3'b110) begin n_fail++; $display("FAIL full_empty: got %b, required 110", vc_empty); end
    n_tests++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL full_pre_drop: got %b, required 0", drop_err); end
    step(8'h00, 2'd0, 1'b0, 1'b0);
    n_tests++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL full_drop_pulse: got %b, required 1", drop_err); end
    step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL full_drop_end: got %b, required 0", drop_err); end
    repeat (5) step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if (vc_empty !== 3'b111) begin n_fail++; $display("FAIL full_drained: got %b, required 111", vc_empty); end
    n_tests++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL full_count: got %0d transfers, required 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      x = obs_q[i]; n_tests++;
      if (x.vc !== 2'd0) begin n_fail++; $display("FAIL full_order[%0d]: got vc%0d, required vc0", i, x.vc); end
      else if (exp_q[0].size() == 0) begin n_fail++; $display("FAIL full_extra[%0d]: got %h, required nothing", i, x.flit); end
      else begin e = exp_q[0].pop_front(); if (x.flit !== e) begin n_fail++; $display("FAIL full_data[%0d]: got %h, required %h", i, x.flit, e); end end
    end
  endtask

  task automatic test_lock();
    logic [1:0] ord [6] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};
    xfer_t x; logic [7:0] e;
    reset_dut();
    step(8'hBC, 2'd0, 1'b0, 1'b1);
    step(8'hBD, 2'd2, 1'b0, 1'b1);
    step(8'h33, 2'd2, 1'b0, 1'b1);
    step(8'hFF, 2'd2, 1'b0, 1'b1);
    step(8'h00, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) step(8'h00, 2'd0, 1'b1, 1'b0);
      else       step(8'h44, 2'd0, 1'b1, 1'b1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lock_gap[%0d]: got out_valid=%b vc%0d, required 0", i, out_valid, out_vc); end
    end
    n_tests++; if (vc_empty[2] !== 1'b0) begin n_fail++; $display("FAIL lock_vc2_wait: got empty=%b, required 0", vc_empty[2]); end
    step(8'hFF, 2'd0, 1'b1, 1'b1);
    n_tests++; if ({out_valid, out_vc, flit_out} !== {1'b1, 2'd0, 8'h44}) begin n_fail++; $display("FAIL lock_resume: got v=%b vc=%0d %h, required v=1 vc=0 44", out_valid, out_vc, flit_out); end
    repeat (6) step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL lock_count: got %0d transfers, required 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      x = obs_q[i]; n_tests++;
      if (x.vc !== ord[i]) begin n_fail++; $display("FAIL lock_order[%0d]: got vc%0d, required vc%0d", i, x.vc, ord[i]); end
      else if (exp_q[x.vc].size() == 0) begin n_fail++; $display("FAIL lock_extra[%0d]: got %h, required nothing", i, x.flit); end
      else begin e = exp_q[x.vc].pop_front(); if (x.flit !== e) begin n_fail++; $display("FAIL lock_data[%0d]: got %h, required %h", i, x.flit, e); end end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ord [10] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [7:0] fl  [9]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h88, 8'h99, 8'hAA};
    logic [1:0] vs  [9]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0};
    xfer_t x; logic [7:0] e;
    reset_dut();
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) step(fl[r*3+j], vs[r*3+j], 1'b0, 1'b1);
      repeat (4) step(8'h00, 2'd0, 1'b1, 1'b0);
    end
    step(8'h77, 2'd0, 1'b1, 1'b1);
    step(8'h00, 2'd0, 1'b1, 1'b0);
    for (int j = 6; j < 9; j++) step(fl[j], vs[j], 1'b0, 1'b1);
    repeat (4) step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if (obs_q.size() != 10) begin n_fail++; $display("FAIL rr_count: got %0d transfers, required 10", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 10; i++) begin
      x = obs_q[i]; n_tests++;
      if (x.vc !== ord[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got vc%0d, required vc%0d", i, x.vc, ord[i]); end
      else if (exp_q[x.vc].size() == 0) begin n_fail++; $display("FAIL rr_extra[%0d]: got %h, required nothing", i, x.flit); end
      else begin e = exp_q[x.vc].pop_front(); if (x.flit !== e) begin n_fail++; $display("FAIL rr_data[%0d]: got %h, required %h", i, x.flit, e); end end
    end
  endtask

  task automatic test_stall();
    logic [1:0] ord [2] = '{2'd2, 2'd0};
    xfer_t x; logic [7:0] e;
    reset_dut();
    step(8'h5A, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      step(8'h66, 2'd0, 1'b0, 1'b1);
      else if (i == 5) step(8'h22, 2'd3, 1'b0, 1'b0);
      else             step(8'h00, 2'd0, 1'b0, 1'b0);
      n_tests++; if ({out_valid, out_vc, flit_out} !== {1'b1, 2'd2, 8'h5A}) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b vc=%0d %h, required v=1 vc=2 5a", i, out_valid, out_vc, flit_out); end
    end
    step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL stall_bad_vc_drop: got %b, required 1", drop_err); end
    repeat (4) step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL stall_count: got %0d transfers, required 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      x = obs_q[i]; n_tests++;
      if (x.vc !== ord[i]) begin n_fail++; $display("FAIL stall_order[%0d]: got vc%0d, required vc%0d", i, x.vc, ord[i]); end
      else if (exp_q[x.vc].size() == 0) begin n_fail++; $display("FAIL stall_extra[%0d]: got %h, required nothing", i, x.flit); end
      else begin e = exp_q[x.vc].pop_front(); if (x.flit !== e) begin n_fail++; $display("FAIL stall_data[%0d]: got %h, required %h", i, x.flit, e); end end
    end
  endtask

  task automatic test_reset_mid_packet();
    reset_dut();
    step(8'hBC, 2'd0, 1'b0, 1'b0);
    step(8'h12, 2'd1, 1'b0, 1'b0);
    step(8'h34, 2'd2, 1'b0, 1'b0);
    step(8'h00, 2'd0, 1'b1, 1'b0);
    step(8'h00, 2'd0, 1'b0, 1'b0);
    n_tests++; if (vc_empty !== 3'b001) begin n_fail++; $display("FAIL mid_pre_empty: got %b, required 001", vc_empty); end
    #1 rst = 1'b0;
    #1;
    n_tests++; if ({flit_out, out_valid, out_vc} !== {8'h00, 1'b0, 2'b00}) begin n_fail++; $display("FAIL mid_rst_out: got %h v=%b vc=%0d, required 00 v=0 vc=0", flit_out, out_valid, out_vc); end
    n_tests++; if ({vc_full, vc_empty, drop_err} !== {3'b000, 3'b111, 1'b0}) begin n_fail++; $display("FAIL mid_rst_flags: got full=%b empty=%b drop=%b, required 000 111 0", vc_full, vc_empty, drop_err); end
    @(negedge clk);
    rst = 1'b1;
    flush_q();
    step(8'h56, 2'd1, 1'b1, 1'b1);
    step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if ({out_valid, out_vc, flit_out} !== {1'b1, 2'd1, 8'h56}) begin n_fail++; $display("FAIL mid_post_grant: got v=%b vc=%0d %h, required v=1 vc=1 56", out_valid, out_vc, flit_out); end
    n_tests++; if (vc_empty !== 3'b101) begin n_fail++; $display("FAIL mid_post_empty: got %b, required 101", vc_empty); end
    step(8'h00, 2'd0, 1'b1, 1'b0);
    n_tests++; if ({out_valid, vc_empty} !== {1'b0, 3'b111}) begin n_fail++; $display("FAIL mid_post_idle: got v=%b empty=%b, required v=0 111", out_valid, vc_empty); end
    n_tests++; if (obs_q.size() != 1 || obs_q[0] !== {2'd1, 8'h56}) begin n_fail++; $display("FAIL mid_post_xfer: got %0d transfers, required one vc1 56", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_packet_latency();
    test_full_drop();
    test_lock();
    test_round_robin();
    test_stall();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
